// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//
// Shared definitions for the two-channel switch debouncer:
//   - state_e               : per-channel filter state (STABLE / PENDING)
//   - DEFAULT_DEBOUNCE_CYCLES: 10 ms of stability at a 100 MHz clock
//   - cnt_width()           : width of a counter that must hold the values
//                             0 .. cycles, never less than one bit
// ---------------------------------------------------------------------------
package debounce_pkg;

  // STABLE : synchronised input matches the output, counter parked at 0.
  // PENDING: synchronised input differs, counter tracks how long it has.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  // Width needed to count up to 'cycles'. Clamped to one bit so a
  // DEBOUNCE_CYCLES of 1 still yields a legal vector.
  function automatic int cnt_width(input int cycles);
    if (cycles < 1) begin
      return 1;
    end
    return (cycles + 1 <= 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//
// One channel of the switch conditioner. A raw asynchronous input is brought
// into the clk domain through two flops, then a stability counter decides
// when the clean output may follow it. The output only changes after the
// synchronised input has differed from it on DEBOUNCE_CYCLES consecutive
// edges; any return to the current output level throws the count away.
// A registered one-cycle pulse marks every output change.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive differing cycles needed to commit (>= 1)
//   CNT_W           - counter width, derived from DEBOUNCE_CYCLES
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   din  - raw asynchronous input
//   dout - debounced level (registered)
//   rise - one-cycle pulse on dout 0->1
//   fall - one-cycle pulse on dout 1->0
// ---------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // Last count value before a commit; reaching it with the input still
  // differing means this edge is the DEBOUNCE_CYCLES-th differing edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchroniser pair: kept adjacent and free of logic in between so the
  // first stage has a full cycle to resolve metastability.
  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;
  logic meta_d;
  logic sync_d;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             out_q;
  logic             out_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;
  logic             commit;

  // Next-state logic for the synchroniser, the stability FSM, the output
  // register and the edge pulses. Pulses default low so they only ever
  // last the single cycle following a commit.
  always_comb begin
    meta_d  = din;
    sync_d  = meta_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;

    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync_q != out_q) begin
          // With a one-cycle window the first differing edge is already
          // the whole window, so there is nothing to wait for.
          if (DEBOUNCE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = CNT_ONE;
          end
        end
      end

      ST_PENDING: begin
        if (sync_q == out_q) begin
          // Input bounced back before the window closed: discard it.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase

    if (commit) begin
      out_d   = sync_q;
      cnt_d   = '0;
      state_d = ST_STABLE;
      rise_d  = sync_q;
      fall_d  = ~sync_q;
    end
  end

  // State register. Reset wins over everything, including a commit that
  // lands on the same edge, so that pulse is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule : debounce_channel

// File: rtl/switch_debounce_2ch.sv
// ---------------------------------------------------------------------------
// switch_debounce_2ch
//
// Two independent debounced inputs feeding the in1/in2 operands of the
// downstream combinational stage. Each channel is a complete
// debounce_channel; nothing is shared between them, so events on both
// inputs are filtered independently and may commit on the same edge.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles before an output follows
//   CNT_W           - counter width, derived from DEBOUNCE_CYCLES
//
// Ports:
//   clk         - clock
//   rst         - synchronous active-high reset
//   in1, in2    - raw asynchronous switch/button inputs
//   out1, out2  - debounced levels
//   rise1/rise2 - one-cycle pulse on the matching output rising
//   fall1/fall2 - one-cycle pulse on the matching output falling
// ---------------------------------------------------------------------------
module switch_debounce_2ch
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in2,
  output logic out1,
  output logic out2,
  output logic rise1,
  output logic rise2,
  output logic fall1,
  output logic fall2
);

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch1 (
    .clk  (clk),
    .rst  (rst),
    .din  (in1),
    .dout (out1),
    .rise (rise1),
    .fall (fall1)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch2 (
    .clk  (clk),
    .rst  (rst),
    .din  (in2),
    .dout (out2),
    .rise (rise2),
    .fall (fall2)
  );

endmodule : switch_debounce_2ch

// File: tb/tb_switch_debounce_2ch.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce_2ch
//
// Drives two debouncers, one with a four-cycle window and one with a
// one-cycle window, from a directed sequence followed by random toggling.
// A behavioural model says what every output must be on every cycle;
// directed steps also pin selected cycles to hand-worked values.
// ---------------------------------------------------------------------------
module tb_switch_debounce_2ch;

  localparam int DC_A = 4;
  localparam int DC_B = 1;

  logic clk = 1'b0;
  logic rst;
  logic a_in1, a_in2, b_in1, b_in2;
  logic a_out1, a_out2, a_rise1, a_rise2, a_fall1, a_fall2;
  logic b_out1, b_out2, b_rise1, b_rise2, b_fall1, b_fall2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_debounce_2ch #(.DEBOUNCE_CYCLES(DC_A)) dut_a (
    .clk   (clk),   .rst   (rst),
    .in1   (a_in1), .in2   (a_in2),
    .out1  (a_out1), .out2 (a_out2),
    .rise1 (a_rise1), .rise2 (a_rise2),
    .fall1 (a_fall1), .fall2 (a_fall2)
  );

  switch_debounce_2ch #(.DEBOUNCE_CYCLES(DC_B)) dut_b (
    .clk   (clk),   .rst   (rst),
    .in1   (b_in1), .in2   (b_in2),
    .out1  (b_out1), .out2 (b_out2),
    .rise1 (b_rise1), .rise2 (b_rise2),
    .fall1 (b_fall1), .fall2 (b_fall2)
  );

  // Behavioural model: raw input reaches the filter two edges after it is
  // sampled; the output flips once the filtered value has disagreed with
  // it for 'window' edges in a row.
  int   window [4] = '{DC_A, DC_A, DC_B, DC_B};
  logic m_seen1 [4];
  logic m_seen2 [4];
  int   m_run   [4];
  logic m_out   [4];
  logic m_rise  [4];
  logic m_fall  [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_seen1[i] = 1'b0; m_seen2[i] = 1'b0; m_run[i] = 0;
      m_out[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
    end
    forever begin
      logic raw [4];
      logic filt;
      @(posedge clk);
      raw[0] = a_in1; raw[1] = a_in2; raw[2] = b_in1; raw[3] = b_in2;
      for (int i = 0; i < 4; i++) begin
        if (rst) begin
          m_seen1[i] = 1'b0; m_seen2[i] = 1'b0; m_run[i] = 0;
          m_out[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
        end else begin
          filt       = m_seen2[i];
          m_seen2[i] = m_seen1[i];
          m_seen1[i] = raw[i];
          m_rise[i]  = 1'b0;
          m_fall[i]  = 1'b0;
          if (filt != m_out[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] >= window[i]) begin
              m_out[i]  = filt;
              m_rise[i] = filt;
              m_fall[i] = ~filt;
              m_run[i]  = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic i1, input logic i2, input logic j1,
                               input logic j2, input logic r, input int n);
    a_in1 = i1; a_in2 = i2; b_in1 = j1; b_in2 = j2; rst = r;
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    logic d_out [4];
    logic d_rise[4];
    logic d_fall[4];
    @(posedge clk);
    forever begin
      @(negedge clk);
      d_out[0] = a_out1; d_out[1] = a_out2; d_out[2] = b_out1; d_out[3] = b_out2;
      d_rise[0] = a_rise1; d_rise[1] = a_rise2; d_rise[2] = b_rise1; d_rise[3] = b_rise2;
      d_fall[0] = a_fall1; d_fall[1] = a_fall2; d_fall[2] = b_fall1; d_fall[3] = b_fall2;
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("model_out[%0d]", i),  d_out[i],  m_out[i]);
        checkOutput($sformatf("model_rise[%0d]", i), d_rise[i], m_rise[i]);
        checkOutput($sformatf("model_fall[%0d]", i), d_fall[i], m_fall[i]);
      end
    end
  end

  initial begin
    a_in1 = 1'b1; a_in2 = 1'b1; b_in1 = 1'b0; b_in2 = 1'b0; rst = 1'b1;
    @(negedge clk);

    // 1: reset with both inputs high, then release
    applyStimulus(1, 1, 0, 0, 1, 3);
    checkOutput("t1_rst_out1", a_out1, 1'b0);
    checkOutput("t1_rst_out2", a_out2, 1'b0);
    checkOutput("t1_rst_rise1", a_rise1, 1'b0);
    applyStimulus(1, 1, 0, 0, 0, 5);
    checkOutput("t1_e4_out1", a_out1, 1'b0);
    checkOutput("t1_e4_out2", a_out2, 1'b0);
    applyStimulus(1, 1, 0, 0, 0, 1);
    checkOutput("t1_e5_out1", a_out1, 1'b1);
    checkOutput("t1_e5_out2", a_out2, 1'b1);
    checkOutput("t1_e5_rise1", a_rise1, 1'b1);
    checkOutput("t1_e5_rise2", a_rise2, 1'b1);
    applyStimulus(1, 1, 0, 0, 0, 1);
    checkOutput("t1_e6_rise1", a_rise1, 1'b0);

    // 2: clean press on channel 1 only
    applyStimulus(0, 0, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 0, 0, 3);
    applyStimulus(1, 0, 0, 0, 0, 5);
    checkOutput("t2_e4_out1", a_out1, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("t2_e5_out1", a_out1, 1'b1);
    checkOutput("t2_e5_rise1", a_rise1, 1'b1);
    checkOutput("t2_out2", a_out2, 1'b0);
    checkOutput("t2_rise2", a_rise2, 1'b0);
    checkOutput("t2_fall2", a_fall2, 1'b0);

    // 3: bounce train then held high
    applyStimulus(0, 0, 0, 0, 1, 2);
    applyStimulus(0, 0, 0, 0, 0, 3);
    applyStimulus(1, 0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 3);
    checkOutput("t3_mid_out1", a_out1, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 5);
    checkOutput("t3_e4_out1", a_out1, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("t3_e5_out1", a_out1, 1'b1);
    checkOutput("t3_e5_rise1", a_rise1, 1'b1);

    // 4: both high, then drop both on the same edge
    applyStimulus(1, 1, 0, 0, 0, 8);
    checkOutput("t4_pre_out1", a_out1, 1'b1);
    checkOutput("t4_pre_out2", a_out2, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 5);
    checkOutput("t4_e4_out1", a_out1, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_e5_fall1", a_fall1, 1'b1);
    checkOutput("t4_e5_fall2", a_fall2, 1'b1);
    checkOutput("t4_e5_out1", a_out1, 1'b0);
    checkOutput("t4_e5_out2", a_out2, 1'b0);
    checkOutput("t4_e5_rise1", a_rise1, 1'b0);
    checkOutput("t4_e5_rise2", a_rise2, 1'b0);

    // 5: reset pulse two edges before channel 2 would commit
    applyStimulus(0, 1, 0, 0, 0, 3);
    checkOutput("t5_pre_out2", a_out2, 1'b0);
    checkOutput("t5_pre_rise2", a_rise2, 1'b0);
    applyStimulus(0, 1, 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 0, 5);
    checkOutput("t5_e4_out2", a_out2, 1'b0);
    checkOutput("t5_e4_rise2", a_rise2, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("t5_e5_out2", a_out2, 1'b1);
    checkOutput("t5_e5_rise2", a_rise2, 1'b1);

    // 6: one-cycle window, press then a one-cycle low glitch
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkOutput("t6_e0_out1", b_out1, 1'b0);
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkOutput("t6_e1_out1", b_out1, 1'b0);
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkOutput("t6_e2_out1", b_out1, 1'b1);
    checkOutput("t6_e2_rise1", b_rise1, 1'b1);
    applyStimulus(0, 1, 1, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkOutput("t6_g1_out1", b_out1, 1'b1);
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkOutput("t6_g2_fall1", b_fall1, 1'b1);
    checkOutput("t6_g2_out1", b_out1, 1'b0);
    applyStimulus(0, 1, 1, 0, 0, 1);
    checkOutput("t6_g3_rise1", b_rise1, 1'b1);
    checkOutput("t6_g3_fall1", b_fall1, 1'b0);
    checkOutput("t6_g3_out1", b_out1, 1'b1);

    // Random bouncing on all four inputs with occasional reset
    for (int c = 0; c < 800; c++) begin
      logic r;
      r = ($urandom_range(99) == 0);
      applyStimulus(($urandom_range(5) == 0) ? ~a_in1 : a_in1,
                    ($urandom_range(3) == 0) ? ~a_in2 : a_in2,
                    ($urandom_range(2) == 0) ? ~b_in1 : b_in1,
                    ($urandom_range(4) == 0) ? ~b_in2 : b_in2,
                    r, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_switch_debounce_2ch
